// File: rtl/aes_256_arb_pkg.sv
// Shared widths, default core latency and tag/requester types for the AES-256
// two-requester arbiter.
package aes_256_arb_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES256_KEY_W    = 256;
    localparam int AES_LAT_DEFAULT = 29;
    localparam int RES_W           = AES_BLOCK_W + 1;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/aes_res_fifo.sv
// First-word-fall-through result buffer. The head word is visible whenever the
// buffer is non-empty and reads as zero while empty.
module aes_res_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush, doPop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign doPush  = push_i && (count_q != FULL);
    assign doPop   = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an empty buffer masks whatever the head slot holds.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= push_data_i;
    end

    always_comb begin
        pop_data_o = '0;
        if (!empty_o) pop_data_o = mem[rdPtr_q];
    end

endmodule

// File: rtl/aes_256_arb.sv
// Round-robin front end sharing one fixed-latency AES-256 core between two
// requesters, with a credit-limited in-order result buffer.
module aes_256_arb
    import aes_256_arb_pkg::*;
#(
    parameter int LAT        = AES_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [AES_BLOCK_W-1:0]  req0_data,
    input  logic [AES256_KEY_W-1:0] req0_key,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [AES_BLOCK_W-1:0]  req1_data,
    input  logic [AES256_KEY_W-1:0] req1_key,
    output logic [AES_BLOCK_W-1:0]  core_state,
    output logic [AES256_KEY_W-1:0] core_key,
    input  logic [AES_BLOCK_W-1:0]  core_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AES_BLOCK_W-1:0]  out_data,
    output logic                    out_id,
    output logic                    busy
);

    localparam int IW   = $clog2(LAT + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW   = $clog2(LAT + FIFO_DEPTH + 1) + 1;

    req_id_e          lastGrant_q, lastGrant_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    tag_t             tag_q [1:LAT];

    logic             creditOk, sel0, sel1, issue;
    req_id_e          issueId;
    logic [CNTW-1:0]  fifoCount;
    logic             fifoEmpty;
    logic [RES_W-1:0] popData;

    // Credit counts blocks in the core plus blocks buffered, so a block can
    // only be issued if its result slot is already guaranteed.
    assign creditOk = (CW'(inflight_q) + CW'(fifoCount)) < CW'(FIFO_DEPTH);

    always_comb begin
        sel0        = req0_valid && (!req1_valid || (lastGrant_q == REQ1));
        sel1        = req1_valid && (!req0_valid || (lastGrant_q == REQ0));
        req0_ready  = !rst && creditOk && sel0;
        req1_ready  = !rst && creditOk && sel1;
        issue       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        issueId     = (req1_valid && req1_ready) ? REQ1 : REQ0;
        core_state  = '0;
        core_key    = '0;
        lastGrant_d = lastGrant_q;
        inflight_d  = inflight_q;
        if (issue) begin
            lastGrant_d = issueId;
            core_state  = (issueId == REQ1) ? req1_data : req0_data;
            core_key    = (issueId == REQ1) ? req1_key  : req0_key;
        end
        case ({issue, tag_q[LAT].valid})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Tags track the core pipeline so a result is captured exactly when the
    // core presents it; clearing them on reset discards stale core outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant_q <= REQ1;
            inflight_q  <= '0;
            for (int i = 1; i <= LAT; i++) tag_q[i] <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            inflight_q  <= inflight_d;
            tag_q[1]    <= '{valid: issue, id: logic'(issueId)};
            for (int i = 2; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    aes_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tag_q[LAT].valid),
        .push_data_i ({core_out, tag_q[LAT].id}),
        .pop_i       (out_valid && out_ready),
        .pop_data_o  (popData),
        .empty_o     (fifoEmpty),
        .count_o     (fifoCount)
    );

    assign out_valid = !fifoEmpty;
    assign out_data  = popData[RES_W-1:1];
    assign out_id    = popData[0];
    assign busy      = (inflight_q != '0) || (fifoCount != '0);

endmodule
